// File: rtl/drt_enumerator_pkg.sv
// Shared constants, state encodings and helpers for the DRT enumerator.
package drt_enumerator_pkg;

  // DRT layout: a fixed header followed by a fixed-size record per device
  localparam int DRT_SIZE_OF_HEADER = 4;
  localparam int DRT_SIZE_OF_DEV    = 4;

  // Field offsets inside a device record
  localparam logic [1:0] DEV_ID       = 2'd0;
  localparam logic [1:0] DEV_INFO     = 2'd1;
  localparam logic [1:0] DEV_MEM_OFF  = 2'd2;
  localparam logic [1:0] DEV_SIZE_OFF = 2'd3;

  // Error codes reported on err_code_o
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_ID   = 2'd1;
  localparam logic [1:0] ERR_TOO_MANY = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Wishbone read engine states
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_GAP  = 2'd2
  } rd_state_t;

  // Enumeration sequencer states; DONE/ERR are transient and fold into IDLE
  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_t;

  // Word pointer of the last word of a table holding n devices
  function automatic logic [15:0] last_word_ptr(input logic [7:0] n);
    return 16'(DRT_SIZE_OF_HEADER - 1) + 16'(DRT_SIZE_OF_DEV) * {8'd0, n};
  endfunction

endpackage

// File: rtl/drt_wb_reader.sv
// Single-word Wishbone read engine: drives cyc/stb for one read, enforces a
// one-cycle strobe-low gap after each ack and aborts on an ack timeout.
module drt_wb_reader
  import drt_enumerator_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        valid_o,
  output logic        timeout_o,
  output logic [31:0] data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  rd_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // State and timeout counter registers; reset drops the bus cycle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RD_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: an ack completes the read, the counter expiring abandons it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_o   = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (req_i) begin
          state_d = RD_READ;
          cnt_d   = 8'd0;
        end
      end
      RD_READ: begin
        if (wbm_ack_i) begin
          valid_o = 1'b1;
          state_d = RD_GAP;
        end else if (cnt_q == ACK_TIMEOUT - 8'd1) begin
          timeout_o = 1'b1;
          state_d   = RD_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_GAP: begin
        // strobe is low here so the slave can release its ack
        if (req_i) begin
          state_d = RD_READ;
          cnt_d   = 8'd0;
        end else begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign data_o    = wbm_dat_i;
  assign wbm_cyc_o = (state_q == RD_READ);
  assign wbm_stb_o = (state_q == RD_READ);
  assign wbm_adr_o = (state_q == RD_READ) ? addr_i : 32'd0;

endmodule

// File: rtl/drt_enumerator.sv
// Walks the Device ROM Table over Wishbone after start, validates the header
// and caches each device record for a combinational lookup port.
module drt_enumerator
  import drt_enumerator_pkg::*;
#(
  parameter int          MAX_DEVICES = 8,
  parameter logic [31:0] DRT_BASE    = 32'h0,
  parameter logic [15:0] EXPECT_ID   = 16'h0001,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] drt_ver_o,
  output logic [7:0]  num_dev_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic [7:0]  lkp_idx_i,
  output logic [31:0] lkp_id_o,
  output logic [31:0] lkp_flags_o,
  output logic [31:0] lkp_base_o,
  output logic [31:0] lkp_size_o
);

  localparam int IDX_W = (MAX_DEVICES > 1) ? $clog2(MAX_DEVICES) : 1;

  seq_state_t       state_q, state_d;
  logic [15:0]      ptr_q, ptr_d;
  logic [7:0]       n_q, n_d;
  logic [IDX_W-1:0] dev_q, dev_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      ver_q, ver_d;
  logic [7:0]       num_q, num_d;
  logic             cache_we;
  logic [31:0]      cache_q [MAX_DEVICES][4];

  logic             rd_valid, rd_timeout;
  logic [31:0]      rd_data;
  logic [15:0]      last_ptr;

  assign last_ptr = last_word_ptr(n_q);

  drt_wb_reader #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_reader (
    .clk       (clk),
    .rst       (rst),
    .req_i     (state_q == SEQ_BUSY),
    .addr_i    (DRT_BASE + {16'd0, ptr_q}),
    .valid_o   (rd_valid),
    .timeout_o (rd_timeout),
    .data_o    (rd_data),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  // Sequencer, pointer and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      ptr_q   <= 16'd0;
      n_q     <= 8'd0;
      dev_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ver_q   <= 16'd0;
      num_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      dev_q   <= dev_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ver_q   <= ver_d;
      num_q   <= num_d;
    end
  end

  // Decode each captured word by its position in the table
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    n_d      = n_q;
    dev_d    = dev_q;
    done_d   = done_q;
    err_d    = err_q;
    code_d   = code_q;
    ver_d    = ver_q;
    num_d    = num_q;
    cache_we = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          state_d = SEQ_BUSY;
          ptr_d   = 16'd0;
          n_d     = 8'd0;
          dev_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          num_d   = 8'd0;
        end
      end
      SEQ_BUSY: begin
        if (rd_timeout) begin
          state_d = SEQ_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          num_d   = 8'd0;
        end else if (rd_valid) begin
          ptr_d = ptr_q + 16'd1;
          if (ptr_q == 16'd0) begin
            if (rd_data[31:16] != EXPECT_ID) begin
              state_d = SEQ_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_BAD_ID;
              num_d   = 8'd0;
            end else begin
              ver_d = rd_data[15:0];
            end
          end else if (ptr_q == 16'd1) begin
            if (rd_data > 32'(MAX_DEVICES)) begin
              state_d = SEQ_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_TOO_MANY;
              num_d   = 8'd0;
            end else begin
              n_d = rd_data[7:0];
            end
          end else begin
            // words 2 and 3 are reserved and simply skipped
            if (ptr_q >= 16'(DRT_SIZE_OF_HEADER)) begin
              cache_we = 1'b1;
              if (ptr_q[1:0] == DEV_SIZE_OFF) dev_d = dev_q + IDX_W'(1);
            end
            if (ptr_q == last_ptr) begin
              state_d = SEQ_IDLE;
              done_d  = 1'b1;
              num_d   = n_q;
            end
          end
        end
      end
    endcase
  end

  // Device cache; validity is tracked solely by num_dev_o
  always_ff @(posedge clk) begin
    if (cache_we) cache_q[dev_q][ptr_q[1:0]] <= rd_data;
  end

  // Combinational lookup, zero for any index beyond the cached count
  always_comb begin
    lkp_id_o    = 32'd0;
    lkp_flags_o = 32'd0;
    lkp_base_o  = 32'd0;
    lkp_size_o  = 32'd0;
    if (lkp_idx_i < num_q) begin
      lkp_id_o    = cache_q[lkp_idx_i[IDX_W-1:0]][DEV_ID];
      lkp_flags_o = cache_q[lkp_idx_i[IDX_W-1:0]][DEV_INFO];
      lkp_base_o  = cache_q[lkp_idx_i[IDX_W-1:0]][DEV_MEM_OFF];
      lkp_size_o  = cache_q[lkp_idx_i[IDX_W-1:0]][DEV_SIZE_OFF];
    end
  end

  assign busy_o     = (state_q == SEQ_BUSY);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign drt_ver_o  = ver_q;
  assign num_dev_o  = num_q;
  assign wbm_we_o   = 1'b0;
  assign wbm_dat_o  = 32'd0;

endmodule

// File: tb/tb_drt_enumerator.sv
// Self-checking bench for drt_enumerator: table vectors, corner sequences and
// randomized DRT images checked against a header-rule reference model.
module tb_drt_enumerator;

  localparam int          MAXD  = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [15:0] EXPID = 16'h0001;
  localparam logic [7:0]  TMO   = 8'd40;

  logic        clk, rst, start_i;
  logic        busy_o, done_o, err_o;
  logic [1:0]  err_code_o;
  logic [15:0] drt_ver_o;
  logic [7:0]  num_dev_o, lkp_idx_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] lkp_id_o, lkp_flags_o, lkp_base_o, lkp_size_o;
  logic        slv_ack = 1'b0;
  logic [31:0] slv_dat = 32'd0;

  drt_enumerator #(
    .MAX_DEVICES(MAXD), .DRT_BASE(BASE), .EXPECT_ID(EXPID), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .drt_ver_o(drt_ver_o),
    .num_dev_o(num_dev_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(slv_dat), .wbm_ack_i(slv_ack), .lkp_idx_i(lkp_idx_i),
    .lkp_id_o(lkp_id_o), .lkp_flags_o(lkp_flags_o), .lkp_base_o(lkp_base_o),
    .lkp_size_o(lkp_size_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRT slave model
  logic [31:0] mem [0:63];
  int slv_reads = 0;
  int addr_errs = 0;
  int lat_cnt   = 0;
  int run_base  = 0;
  int max_lat   = 0;
  int ack_cut   = -1;
  bit no_ack    = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] adr);
    logic [31:0] off;
    off = adr - BASE;
    if (off < 32'd64) return mem[off[5:0]];
    return 32'hBAD0_BAD0;
  endfunction

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      if (!slv_ack) begin
        if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
        else if (!no_ack && (ack_cut < 0 || (slv_reads - run_base) < ack_cut)) begin
          slv_ack <= 1'b1;
          slv_dat <= mem_rd(wbm_adr_o);
          if (wbm_adr_o != BASE + 32'(slv_reads - run_base)) addr_errs <= addr_errs + 1;
          slv_reads <= slv_reads + 1;
        end
      end
    end else begin
      slv_ack <= 1'b0;
      slv_dat <= 32'd0;
      lat_cnt <= int'($urandom_range(0, 32'(max_lat)));
    end
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ver = 16'd0;
  int stb_cycles = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [31:0] w0, input logic [31:0] n);
    mem[0] = w0;
    mem[1] = n;
    for (int i = 2; i < 64; i++) mem[i] = $urandom();
  endtask

  // Reference: the header alone decides the outcome and the read count
  task automatic model(output bit m_done, output logic [1:0] m_code,
                       output int m_reads, output int m_ndev);
    if (mem[0][31:16] != EXPID) begin
      m_done = 1'b0; m_code = 2'd1; m_reads = 1; m_ndev = 0;
    end else begin
      exp_ver = mem[0][15:0];
      if (mem[1] > 32'(MAXD)) begin
        m_done = 1'b0; m_code = 2'd2; m_reads = 2; m_ndev = 0;
      end else begin
        m_ndev = int'(mem[1]);
        m_done = 1'b1; m_code = 2'd0; m_reads = 4 + 4 * m_ndev;
      end
    end
  endtask

  task automatic run_enum(input int budget, input bit noise);
    int n;
    run_base = slv_reads;
    stb_cycles = 0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (busy_o && n < budget) begin
      if (wbm_stb_o) stb_cycles++;
      start_i = noise && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check("run_finished", 128'(busy_o), 128'(0));
  endtask

  task automatic check_result(input string tag, input bit e_done, input logic [1:0] e_code,
                              input int e_reads, input int e_ndev);
    check({tag, "_done"}, 128'(done_o), 128'(e_done));
    check({tag, "_err"}, 128'(err_o), 128'(!e_done));
    check({tag, "_code"}, 128'(err_code_o), 128'(e_code));
    check({tag, "_reads"}, 128'(slv_reads - run_base), 128'(e_reads));
    check({tag, "_ndev"}, 128'(num_dev_o), 128'(e_ndev));
    check({tag, "_ver"}, 128'(drt_ver_o), 128'(exp_ver));
    check({tag, "_bus_idle"}, 128'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_dat_o}), 128'(0));
    check({tag, "_adr_seq"}, 128'(addr_errs), 128'(0));
  endtask

  task automatic check_table(input string tag, input int ndev);
    logic [127:0] expv;
    for (int i = 0; i <= MAXD + 1; i++) begin
      lkp_idx_i = 8'(i);
      #1;
      if (i < ndev) expv = {mem[4+4*i], mem[5+4*i], mem[6+4*i], mem[7+4*i]};
      else expv = '0;
      check($sformatf("%s_lkp%0d", tag, i), {lkp_id_o, lkp_flags_o, lkp_base_o, lkp_size_o}, expv);
    end
    lkp_idx_i = 8'hFF;
    #1;
    check({tag, "_lkp255"}, {lkp_id_o, lkp_flags_o, lkp_base_o, lkp_size_o}, '0);
    lkp_idx_i = 8'd0;
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] n;
    bit          exp_done;
    logic [1:0]  exp_code;
    int          exp_reads;
    int          exp_ndev;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  initial begin
    bit m_done;
    logic [1:0] m_code;
    int m_reads, m_ndev, n;
    bit found;

    vecs[0] = '{32'h0001_0001, 32'd2,          1'b1, 2'd0, 12, 2};
    vecs[1] = '{32'hBEEF_0001, 32'd2,          1'b0, 2'd1, 1,  0};
    vecs[2] = '{32'h0001_0002, 32'd9,          1'b0, 2'd2, 2,  0};
    vecs[3] = '{32'h0001_0003, 32'd0,          1'b1, 2'd0, 4,  0};
    vecs[4] = '{32'h0001_0004, 32'd8,          1'b1, 2'd0, 36, 8};
    vecs[5] = '{32'h0001_ABCD, 32'd1,          1'b1, 2'd0, 8,  1};
    vecs[6] = '{32'h0001_0005, 32'h8000_0001,  1'b0, 2'd2, 2,  0};
    vecs[7] = '{32'h0001_0006, 32'd256,        1'b0, 2'd2, 2,  0};

    rst = 1'b0; start_i = 1'b0; lkp_idx_i = 8'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs",
          128'({busy_o, done_o, err_o, err_code_o, drt_ver_o, num_dev_o, wbm_cyc_o,
                wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}), 128'(0));
    check("reset_lkp", {lkp_id_o, lkp_flags_o, lkp_base_o, lkp_size_o}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reference DRT image with known device records
    mem[0] = 32'h0001_0001; mem[1] = 32'd2; mem[2] = 32'd0; mem[3] = 32'd0;
    mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC; mem[7] = 32'hD;
    mem[8] = 32'hE; mem[9] = 32'hF; mem[10] = 32'h10; mem[11] = 32'h20;
    exp_ver = 16'h0001;
    run_enum(1000, 1'b0);
    check_result("ref", 1'b1, 2'd0, 12, 2);
    lkp_idx_i = 8'd1;
    #1;
    check("ref_base1", 128'(lkp_base_o), 128'(32'h10));
    check("ref_size1", 128'(lkp_size_o), 128'(32'h20));
    check_table("ref", 2);

    // Table vectors
    for (int v = 0; v < NVEC; v++) begin
      fill_mem(vecs[v].w0, vecs[v].n);
      if (vecs[v].w0[31:16] == EXPID) exp_ver = vecs[v].w0[15:0];
      max_lat = v % 3;
      run_enum(2000, 1'b0);
      check_result($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_code,
                   vecs[v].exp_reads, vecs[v].exp_ndev);
      check_table($sformatf("vec%0d", v), vecs[v].exp_ndev);
    end

    // Slave never acks the first word
    fill_mem(32'h0001_0077, 32'd2);
    no_ack = 1'b1;
    run_enum(500, 1'b0);
    no_ack = 1'b0;
    check_result("tmo0", 1'b0, 2'd3, 0, 0);
    check("tmo0_stb_cycles", 128'(stb_cycles), 128'(TMO));

    // Slave stops acking after five words
    fill_mem(32'h0001_0078, 32'd2);
    exp_ver = 16'h0078;
    ack_cut = 5;
    run_enum(1000, 1'b0);
    ack_cut = -1;
    check_result("tmo5", 1'b0, 2'd3, 5, 0);
    check_table("tmo5", 0);

    // Reset while word 6 is being read, then restart with start noise
    fill_mem(32'h0001_0042, 32'd2);
    max_lat = 2;
    run_base = slv_reads;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == BASE + 32'd6) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_word6", 128'(wbm_stb_o && wbm_adr_o == BASE + 32'd6), 128'(1));
    #1 rst = 1'b1;
    #1;
    exp_ver = 16'd0;
    check("rst_mid_outputs",
          128'({busy_o, done_o, err_o, err_code_o, drt_ver_o, num_dev_o, wbm_cyc_o,
                wbm_stb_o, wbm_adr_o}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    model(m_done, m_code, m_reads, m_ndev);
    run_enum(2000, 1'b1);
    check_result("restart", m_done, m_code, m_reads, m_ndev);
    check_table("restart", m_ndev);

    // Start arriving together with the final ack is ignored
    fill_mem(32'h0001_0099, 32'd1);
    exp_ver = 16'h0099;
    max_lat = 1;
    run_base = slv_reads;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      if (wbm_stb_o && slv_ack && wbm_adr_o == BASE + 32'd7) begin
        start_i = 1'b1;
        found = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check("lastack_seen", 128'(found), 128'(1));
    repeat (3) @(negedge clk);
    check("lastack_no_restart", 128'(busy_o), 128'(0));
    check_result("lastack", 1'b1, 2'd0, 8, 1);
    check_table("lastack", 1);

    // Randomized images against the reference model
    for (int r = 0; r < 12; r++) begin
      logic [31:0] w0, nn;
      w0 = ($urandom_range(0, 3) == 0) ? $urandom() : {EXPID, 16'($urandom())};
      case ($urandom_range(0, 5))
        0:       nn = $urandom();
        1:       nn = 32'($urandom_range(9, 12));
        default: nn = 32'($urandom_range(0, MAXD));
      endcase
      fill_mem(w0, nn);
      max_lat = int'($urandom_range(0, 3));
      model(m_done, m_code, m_reads, m_ndev);
      run_enum(3000, 1'b1);
      check_result($sformatf("rnd%0d", r), m_done, m_code, m_reads, m_ndev);
      check_table($sformatf("rnd%0d", r), m_ndev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
